in_bus_arbiter: RTL and testbench

- Round-robin arbiter that shares the single in_bus request port among NUM_REQ independent requesters (host ports, test engines).
- Selects one eligible request, drives the in_bus input fields for exactly one cycle, then enforces a guard gap so the per-switch FIFO full flags settle before the next grant.
- Blocks requests that target a full switch FIFO and drops requests that target a nonexistent switch.

---
 rtl/in_bus_arbiter_if.sv | 38 +++
 rtl/in_bus_arbiter.sv | 160 ++++++++++++++++
 tb/tb_in_bus_arbiter.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/in_bus_arbiter_if.sv
// Requester-side and in_bus-side signal bundle for in_bus_arbiter.
// master = arbiter view, slave = requesters / in_bus / switch FIFO view.
interface in_bus_arbiter_if #(
    parameter int unsigned NUM_REQ     = 4,
    parameter int unsigned NUM_SW_INST = 5,
    parameter int unsigned W_WIDTH     = 8
);
    localparam int unsigned ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic                       arb_en;
    logic [NUM_REQ-1:0]         req_valid;
    logic [NUM_REQ-1:0]         req_wr_rd_op;
    logic [NUM_REQ*8-1:0]       req_op_id;
    logic [NUM_REQ*8-1:0]       req_addr;
    logic [NUM_REQ*W_WIDTH-1:0] req_wr_data;
    logic [NUM_REQ-1:0]         req_ready;
    logic [NUM_SW_INST-1:0]     fifo_full;
    logic                       bus_en;
    logic                       bus_valid;
    logic                       bus_wr_rd_op;
    logic [7:0]                 bus_op_id;
    logic [7:0]                 bus_addr;
    logic [W_WIDTH-1:0]         bus_wr_data;
    logic [ID_W-1:0]            grant_id;
    logic                       addr_err;

    modport master (
        input  arb_en, req_valid, req_wr_rd_op, req_op_id, req_addr, req_wr_data, fifo_full,
        output req_ready, bus_en, bus_valid, bus_wr_rd_op, bus_op_id, bus_addr, bus_wr_data,
               grant_id, addr_err
    );

    modport slave (
        output arb_en, req_valid, req_wr_rd_op, req_op_id, req_addr, req_wr_data, fifo_full,
        input  req_ready, bus_en, bus_valid, bus_wr_rd_op, bus_op_id, bus_addr, bus_wr_data,
               grant_id, addr_err
    );
endinterface

// File: rtl/in_bus_arbiter.sv
// Round-robin arbiter sharing the in_bus request port, with a guard gap after each grant.
// Define IN_BUS_ARB_FIXED_PRIO_EN for fixed priority (lowest eligible index wins).
module in_bus_arbiter #(
    parameter int unsigned NUM_REQ     = 4,
    parameter int unsigned NUM_SW_INST = 5,
    parameter int unsigned W_WIDTH     = 8,
    parameter int unsigned GAP_CYC     = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    in_bus_arbiter_if.master   bus_if
);
    localparam int unsigned ID_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned CNT_W    = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
    localparam int unsigned GAP_LAST = (GAP_CYC > 0) ? GAP_CYC - 1 : 0;

    typedef enum logic [1:0] {IDLE = 2'd0, GRANT = 2'd1, WAIT = 2'd2} state_t;

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic [ID_W-1:0]    ptr, ptr_nxt;
    logic [NUM_REQ-1:0] elig, bad;
    logic               found;
    logic [ID_W-1:0]    win;
    logic               win_bad;

    logic               valid_nxt, wr_nxt, err_nxt;
    logic [NUM_REQ-1:0] ready_nxt;
    logic [7:0]         op_nxt, addr_nxt;
    logic [W_WIDTH-1:0] data_nxt;
    logic [ID_W-1:0]    gid_nxt;

    function automatic logic [ID_W-1:0] inc_idx(logic [ID_W-1:0] x);
        return ID_W'((32'(x) + 32'd1) % NUM_REQ);
    endfunction

    // Out-of-range targets stay eligible so they can be accepted and dropped.
    always_comb begin
        elig = '0;
        bad  = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            logic [2:0] sw;
            logic       full;
            sw   = bus_if.req_addr[8*i+5 +: 3];
            full = 1'b0;
            for (int unsigned s = 0; s < NUM_SW_INST; s++) begin
                if (32'(sw) == s) full = bus_if.fifo_full[s];
            end
            bad[i]  = (32'(sw) >= NUM_SW_INST);
            elig[i] = bus_if.req_valid[i] & (bad[i] | ~full);
        end
    end

    // First eligible requester at or after the pointer.
    always_comb begin
        found = 1'b0;
        win   = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                if (!found && (i == (32'(ptr) + k) % NUM_REQ) && elig[i]) begin
                    found = 1'b1;
                    win   = ID_W'(i);
                end
            end
        end
    end

    assign win_bad = bad[win];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state               <= IDLE;
            cnt                 <= '0;
            ptr                 <= '0;
            bus_if.bus_en       <= 1'b0;
            bus_if.bus_valid    <= 1'b0;
            bus_if.bus_wr_rd_op <= 1'b0;
            bus_if.bus_op_id    <= '0;
            bus_if.bus_addr     <= '0;
            bus_if.bus_wr_data  <= '0;
            bus_if.req_ready    <= '0;
            bus_if.grant_id     <= '0;
            bus_if.addr_err     <= 1'b0;
        end else begin
            state               <= state_nxt;
            cnt                 <= cnt_nxt;
            ptr                 <= ptr_nxt;
            bus_if.bus_en       <= bus_if.arb_en;
            bus_if.bus_valid    <= valid_nxt;
            bus_if.bus_wr_rd_op <= wr_nxt;
            bus_if.bus_op_id    <= op_nxt;
            bus_if.bus_addr     <= addr_nxt;
            bus_if.bus_wr_data  <= data_nxt;
            bus_if.req_ready    <= ready_nxt;
            bus_if.grant_id     <= gid_nxt;
            bus_if.addr_err     <= err_nxt;
        end
    end

    // Next state; arb_en only gates leaving IDLE so in-flight transfers complete.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        unique case (state)
            IDLE: begin
                if (bus_if.arb_en && found && !win_bad) state_nxt = GRANT;
            end
            GRANT: begin
                cnt_nxt   = '0;
                state_nxt = (GAP_CYC > 0) ? WAIT : IDLE;
            end
            WAIT: begin
                if (32'(cnt) == GAP_LAST) state_nxt = IDLE;
                else                      cnt_nxt   = cnt + CNT_W'(1);
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Registered-output next values; bus fields hold unless a new grant is latched.
    always_comb begin
        valid_nxt = 1'b0;
        ready_nxt = '0;
        err_nxt   = 1'b0;
        wr_nxt    = bus_if.bus_wr_rd_op;
        op_nxt    = bus_if.bus_op_id;
        addr_nxt  = bus_if.bus_addr;
        data_nxt  = bus_if.bus_wr_data;
        gid_nxt   = bus_if.grant_id;
        ptr_nxt   = ptr;
        unique case (state)
            IDLE: begin
                if (bus_if.arb_en && found) begin
                    ready_nxt[win] = 1'b1;
                    if (win_bad) begin
                        err_nxt = 1'b1;
                        ptr_nxt = inc_idx(win);
                    end else begin
                        valid_nxt = 1'b1;
                        gid_nxt   = win;
                        for (int unsigned i = 0; i < NUM_REQ; i++) begin
                            if (ID_W'(i) == win) begin
                                wr_nxt   = bus_if.req_wr_rd_op[i];
                                op_nxt   = bus_if.req_op_id[8*i +: 8];
                                addr_nxt = bus_if.req_addr[8*i +: 8];
                                data_nxt = bus_if.req_wr_data[W_WIDTH*i +: W_WIDTH];
                            end
                        end
                    end
                end
            end
            GRANT:   ptr_nxt = inc_idx(bus_if.grant_id);
            default: ;
        endcase
`ifdef IN_BUS_ARB_FIXED_PRIO_EN
        ptr_nxt = '0;
`else
`endif
    end
endmodule

// File: tb/tb_in_bus_arbiter.sv
// Directed bench for in_bus_arbiter with a cycle-budget reference model and literal spot checks.
module tb_in_bus_arbiter;
    localparam int NREQ = 4;
    localparam int NSW  = 5;
    localparam int WW   = 8;
    localparam int GAP  = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    in_bus_arbiter_if #(.NUM_REQ(NREQ), .NUM_SW_INST(NSW), .W_WIDTH(WW)) bif ();

    in_bus_arbiter #(.NUM_REQ(NREQ), .NUM_SW_INST(NSW), .W_WIDTH(WW), .GAP_CYC(GAP)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus_if(bif)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Model: a new arbitration is allowed at cycle next_arb; a grant costs 2+GAP cycles.
    int cyc = 0, next_arb = 0, m_ptr = 0;
    logic       e_en, e_valid, e_wr, e_err;
    logic [3:0] e_ready;
    logic [7:0] e_op, e_addr, e_data;
    logic [1:0] e_gid;

    typedef struct { int cyc; int gid; } glog_t;
    glog_t glog[$];
    bit auto_drop = 0;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        if (!rst_n) begin
            {e_en, e_valid, e_wr, e_err} = '0;
            e_ready = '0; e_op = '0; e_addr = '0; e_data = '0; e_gid = '0;
            m_ptr = 0;
            next_arb = cyc + 1;
        end else begin
            int w = -1;
            e_en = bif.arb_en; e_valid = 1'b0; e_ready = '0; e_err = 1'b0;
            if (bif.arb_en && cyc >= next_arb) begin
                for (int k = 0; k < NREQ; k++) begin
                    int i, sw;
                    i  = (m_ptr + k) % NREQ;
                    sw = int'(bif.req_addr[8*i+5 +: 3]);
                    if (w < 0 && bif.req_valid[i] && (sw >= NSW || !bif.fifo_full[sw])) w = i;
                end
                if (w >= 0) begin
                    e_ready[w] = 1'b1;
                    if (int'(bif.req_addr[8*w+5 +: 3]) >= NSW) begin
                        e_err = 1'b1;
                        next_arb = cyc + 1;
                    end else begin
                        e_valid = 1'b1;
                        e_gid   = 2'(w);
                        e_wr    = bif.req_wr_rd_op[w];
                        e_op    = bif.req_op_id[8*w +: 8];
                        e_addr  = bif.req_addr[8*w +: 8];
                        e_data  = bif.req_wr_data[WW*w +: WW];
                        next_arb = cyc + 2 + GAP;
                    end
`ifdef IN_BUS_ARB_FIXED_PRIO_EN
                    m_ptr = 0;
`else
                    m_ptr = (w + 1) % NREQ;
`endif
                end
            end
        end
        cyc++;
    endtask

    task automatic compare_step();
        chk("bus_en",       bif.bus_en,       e_en);
        chk("bus_valid",    bif.bus_valid,    e_valid);
        chk("bus_wr_rd_op", bif.bus_wr_rd_op, e_wr);
        chk("bus_op_id",    bif.bus_op_id,    e_op);
        chk("bus_addr",     bif.bus_addr,     e_addr);
        chk("bus_wr_data",  bif.bus_wr_data,  e_data);
        chk("req_ready",    bif.req_ready,    e_ready);
        chk("grant_id",     bif.grant_id,     e_gid);
        chk("addr_err",     bif.addr_err,     e_err);
        if (bif.bus_valid === 1'b1) glog.push_back('{cyc, int'(bif.grant_id)});
    endtask

    always @(posedge clk) begin
        model_step();
        #1;
        compare_step();
    end

    task automatic tick();
        @(negedge clk);
        if (auto_drop) bif.req_valid = bif.req_valid & ~bif.req_ready;
    endtask

    task automatic sample();
        @(posedge clk);
        #2;
    endtask

    task automatic set_req(int i, logic [7:0] addr, logic [7:0] op, logic [7:0] data, logic wr);
        bif.req_addr[8*i +: 8]     = addr;
        bif.req_op_id[8*i +: 8]    = op;
        bif.req_wr_data[WW*i +: WW] = data;
        bif.req_wr_rd_op[i]        = wr;
        bif.req_valid[i]           = 1'b1;
    endtask

    task automatic do_reset();
        tick();
        rst_n = 1'b0;
        bif.req_valid = '0;
        bif.fifo_full = '0;
        auto_drop = 0;
        repeat (2) tick();
        rst_n = 1'b1;
        glog.delete();
    endtask

    initial begin
        bit seen;
        int exp_seq[4];
        bif.arb_en = 1'b0; bif.req_valid = '0; bif.req_wr_rd_op = '0;
        bif.req_op_id = '0; bif.req_addr = '0; bif.req_wr_data = '0; bif.fifo_full = '0;

        // reset state
        repeat (3) tick();
        chk("rst_bus_valid", bif.bus_valid, 0);
        chk("rst_req_ready", bif.req_ready, 0);
        chk("rst_grant_id",  bif.grant_id,  0);
        chk("rst_bus_en",    bif.bus_en,    0);
        rst_n = 1'b1;
        bif.arb_en = 1'b1;

        // single request, then a back-to-back reissue from the same requester
        auto_drop = 1;
        set_req(2, 8'h43, 8'h11, 8'hA5, 1'b1);
        sample();
        chk("s1_valid", bif.bus_valid,    1);
        chk("s1_addr",  bif.bus_addr,     32'h43);
        chk("s1_data",  bif.bus_wr_data,  32'hA5);
        chk("s1_opid",  bif.bus_op_id,    32'h11);
        chk("s1_wr",    bif.bus_wr_rd_op, 1);
        chk("s1_ready", bif.req_ready,    4'b0100);
        chk("s1_gid",   bif.grant_id,     2);
        tick();
        set_req(2, 8'h43, 8'h12, 8'h5A, 1'b0);
        repeat (8) tick();
        chk("s1_ngrants", glog.size(), 2);
        if (glog.size() >= 2) chk("s1_spacing", glog[1].cyc - glog[0].cyc, 4);

        // three requesters held valid continuously
        do_reset();
        set_req(0, 8'h01, 8'h20, 8'h10, 1'b1);
        set_req(1, 8'h22, 8'h21, 8'h11, 1'b0);
        set_req(3, 8'h64, 8'h23, 8'h13, 1'b1);
        repeat (20) tick();
`ifdef IN_BUS_ARB_FIXED_PRIO_EN
        exp_seq = '{0, 0, 0, 0};
`else
        exp_seq = '{0, 1, 3, 0};
`endif
        chk("s3_enough_grants", glog.size() >= 4, 1);
        for (int k = 0; k < 4; k++) begin
            if (k < glog.size()) chk("s3_order", glog[k].gid, exp_seq[k]);
            if (k > 0 && k < glog.size()) chk("s3_spacing", glog[k].cyc - glog[k-1].cyc, 4);
        end

        // full switch FIFO blocks requester 1 until it clears
        do_reset();
        auto_drop = 1;
        bif.fifo_full[4] = 1'b1;
        set_req(1, 8'h85, 8'h31, 8'h77, 1'b1);
        set_req(3, 8'h02, 8'h33, 8'h88, 1'b1);
        repeat (12) tick();
        chk("s4_blocked_ngrants", glog.size(), 1);
        if (glog.size() >= 1) chk("s4_first_gid", glog[0].gid, 3);
        bif.fifo_full[4] = 1'b0;
        repeat (6) tick();
        chk("s4_unblocked_ngrants", glog.size(), 2);
        if (glog.size() >= 2) chk("s4_second_gid", glog[1].gid, 1);

        // nonexistent switch is accepted and dropped
        do_reset();
        auto_drop = 1;
        set_req(0, 8'hE0, 8'h40, 8'h99, 1'b1);
        sample();
        chk("s5_ready",    bif.req_ready, 4'b0001);
        chk("s5_addr_err", bif.addr_err,  1);
        chk("s5_valid",    bif.bus_valid, 0);
        tick();
        sample();
        chk("s5_err_pulse", bif.addr_err,  0);
        chk("s5_ready_end", bif.req_ready, 0);
        chk("s5_ngrants",   glog.size(),   0);

        // arb_en low holds off grants; reset during WAIT restarts from requester 0
        do_reset();
        bif.arb_en = 1'b0;
        set_req(1, 8'h21, 8'h51, 8'h01, 1'b1);
        set_req(3, 8'h61, 8'h53, 8'h03, 1'b1);
        repeat (6) tick();
        chk("s6_no_grants", glog.size(), 0);
        chk("s6_bus_en",    bif.bus_en,  0);
        bif.arb_en = 1'b1;
        seen = 0;
        for (int t = 0; t < 10 && !seen; t++) begin
            sample();
            if (bif.bus_valid === 1'b1) seen = 1;
        end
        chk("s6_grant_seen", seen, 1);
        chk("s6_gid", bif.grant_id, 1);
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        chk("s6_rst_valid", bif.bus_valid, 0);
        chk("s6_rst_ready", bif.req_ready, 0);
        chk("s6_rst_gid",   bif.grant_id,  0);
        chk("s6_rst_addr",  bif.bus_addr,  0);
        chk("s6_rst_opid",  bif.bus_op_id, 0);
        chk("s6_rst_en",    bif.bus_en,    0);
        repeat (2) tick();
        rst_n = 1'b1;
        glog.delete();
        repeat (3) tick();
        chk("s6_resume_seen", glog.size() > 0, 1);
        if (glog.size() > 0) chk("s6_resume_gid", glog[0].gid, 1);

        bif.req_valid = '0;
        repeat (2) tick();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
